// File: rtl/dtype_cast_engine_pkg.sv
// Shared dtype codes, FSM state encoding and conversion result type for the cast engine.
package dtype_cast_engine_pkg;

    localparam logic [7:0] DT_INT8  = 8'd0;
    localparam logic [7:0] DT_FP16  = 8'd1;
    localparam logic [7:0] DT_INT32 = 8'd2;

    typedef enum logic [2:0] {
        CE_IDLE,
        CE_READ,
        CE_WAIT,
        CE_WRITE,
        CE_DONE
    } ce_state_t;

    typedef struct packed {
        logic [7:0] val;
        logic       sat;
    } i8_res_t;

    // Only INT8 and FP16 are convertible; INT32 and anything above is rejected.
    function automatic logic dtype_ok(input logic [7:0] dt);
        return (dt == DT_INT8) || (dt == DT_FP16);
    endfunction

endpackage

// File: rtl/dtype_cast_engine_if.sv
// Command, status and byte-wide SRAM port bundle of the dtype cast engine.
interface dtype_cast_engine_if #(
    parameter int unsigned SRAM0_AW = 16,
    parameter int unsigned LEN_W    = 16
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [SRAM0_AW-1:0] cmd_src_base;
    logic [SRAM0_AW-1:0] cmd_dst_base;
    logic [LEN_W-1:0]    cmd_length;
    logic [7:0]          cmd_src_dtype;
    logic [7:0]          cmd_dst_dtype;
    logic                sram_rd_en;
    logic [SRAM0_AW-1:0] sram_rd_addr;
    logic [7:0]          sram_rd_data;
    logic                sram_wr_en;
    logic [SRAM0_AW-1:0] sram_wr_addr;
    logic [7:0]          sram_wr_data;
    logic                busy;
    logic                done;
    logic                err;
    logic [LEN_W-1:0]    sat_count;

    modport slave (
        input  cmd_valid, cmd_src_base, cmd_dst_base, cmd_length,
               cmd_src_dtype, cmd_dst_dtype, sram_rd_data,
        output cmd_ready, sram_rd_en, sram_rd_addr, sram_wr_en,
               sram_wr_addr, sram_wr_data, busy, done, err, sat_count
    );

    modport master (
        output cmd_valid, cmd_src_base, cmd_dst_base, cmd_length,
               cmd_src_dtype, cmd_dst_dtype, sram_rd_data,
        input  cmd_ready, sram_rd_en, sram_rd_addr, sram_wr_en,
               sram_wr_addr, sram_wr_data, busy, done, err, sat_count
    );
endinterface

// File: rtl/fp16_int8_conv.sv
// Combinational INT8<->FP16 converters: exact widening, RNE narrowing with saturation flag.
module fp16_int8_conv
    import dtype_cast_engine_pkg::*;
(
    input  logic [7:0]  i_i8,
    input  logic [15:0] i_f16,
    output logic [15:0] o_f16_c,
    output i8_res_t     o_i8_c
);

    logic [7:0]  w_mag;
    logic [2:0]  w_msb;
    logic [9:0]  w_mant;
    logic        w_s;
    logic [4:0]  w_e;
    logic [9:0]  w_m;
    logic [4:0]  w_sh;
    logic [21:0] w_shv;
    logic        w_rnd;
    logic [8:0]  w_q;

    always_comb begin : int8_to_fp16
        w_mag = i_i8[7] ? 8'(-i_i8) : i_i8;
        w_msb = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_mag[i]) w_msb = 3'(i);
        end
        w_mant  = 10'({w_mag, 10'd0} >> w_msb);
        o_f16_c = (i_i8 == 8'd0) ? 16'd0 : {i_i8[7], 5'(5'd15 + 5'(w_msb)), w_mant};
    end

    // Significand sits at bit 21 of a 22-bit window; bits [21:11] are the integer part.
    always_comb begin : fp16_to_int8
        w_s    = i_f16[15];
        w_e    = i_f16[14:10];
        w_m    = i_f16[9:0];
        w_sh   = 5'(5'd25 - w_e);
        w_shv  = {1'b1, w_m, 11'd0} >> w_sh;
        w_rnd  = w_shv[10] & ((|w_shv[9:0]) | w_shv[11]);
        w_q    = 9'(w_shv[21:11]) + 9'(w_rnd);
        o_i8_c = '0;
        if (w_e == 5'd31) begin
            o_i8_c.sat = 1'b1;
            if (w_m == 10'd0) o_i8_c.val = w_s ? 8'h80 : 8'h7F;
        end else if (w_e >= 5'd23) begin
            o_i8_c.sat = 1'b1;
            o_i8_c.val = w_s ? 8'h80 : 8'h7F;
        end else if (w_e >= 5'd14) begin
            if (w_s) begin
                if (w_q > 9'd128) begin
                    o_i8_c.sat = 1'b1;
                    o_i8_c.val = 8'h80;
                end else begin
                    o_i8_c.val = 8'(9'd0 - w_q);
                end
            end else if (w_q > 9'd127) begin
                o_i8_c.sat = 1'b1;
                o_i8_c.val = 8'h7F;
            end else begin
                o_i8_c.val = w_q[7:0];
            end
        end
    end

endmodule

// File: rtl/dtype_cast_engine.sv
// Element-wise INT8/FP16 cast engine: byte-serial SRAM read, convert, byte-serial write.
module dtype_cast_engine
    import dtype_cast_engine_pkg::*;
#(
    parameter int unsigned SRAM0_AW = 16,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dtype_cast_engine_if.slave  bus
);

    localparam int unsigned WC_W = $clog2(RD_LAT + 1);

    ce_state_t           r_state, w_state_nxt;
    logic [SRAM0_AW-1:0] r_src_base, w_src_base_nxt, r_dst_base, w_dst_base_nxt;
    logic [LEN_W-1:0]    r_length, w_length_nxt, r_index, w_index_nxt;
    logic                r_src16, w_src16_nxt, r_dst16, w_dst16_nxt, r_k, w_k_nxt;
    logic [WC_W-1:0]     r_wcnt, w_wcnt_nxt;
    logic [15:0]         r_src, w_src_nxt;
    logic                r_cmd_ready, w_cmd_ready_nxt, r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt, r_err, w_err_nxt;
    logic                r_rd_en, w_rd_en_nxt, r_wr_en, w_wr_en_nxt;
    logic [SRAM0_AW-1:0] r_rd_addr, w_rd_addr_nxt, r_wr_addr, w_wr_addr_nxt;
    logic [7:0]          r_wr_data, w_wr_data_nxt;
    logic [LEN_W-1:0]    r_sat_count, w_sat_nxt;
    logic                w_capture;
    logic [15:0]         w_f16, w_dst_word;
    i8_res_t             w_i8;

    // Source register capture at the end of the last WAIT cycle.
    always_comb begin : src_capture
        w_capture = (r_state == CE_WAIT) && (r_wcnt == WC_W'(RD_LAT - 1));
        w_src_nxt = r_src;
        if (w_capture) w_src_nxt = r_k ? {bus.sram_rd_data, r_src[7:0]} : {r_src[15:8], bus.sram_rd_data};
    end

    fp16_int8_conv u_conv (
        .i_i8    (w_src_nxt[7:0]),
        .i_f16   (w_src_nxt),
        .o_f16_c (w_f16),
        .o_i8_c  (w_i8)
    );

    always_comb begin : dst_select
        case ({r_src16, r_dst16})
            2'b01:   w_dst_word = w_f16;
            2'b10:   w_dst_word = {8'h00, w_i8.val};
            default: w_dst_word = w_src_nxt;
        endcase
    end

    always_comb begin : fsm_next
        w_state_nxt    = r_state;
        w_src_base_nxt = r_src_base;
        w_dst_base_nxt = r_dst_base;
        w_length_nxt   = r_length;
        w_src16_nxt    = r_src16;
        w_dst16_nxt    = r_dst16;
        w_index_nxt    = r_index;
        w_k_nxt        = r_k;
        w_wcnt_nxt     = r_wcnt;
        w_err_nxt      = r_err;
        w_sat_nxt      = r_sat_count;
        w_rd_addr_nxt  = r_rd_addr;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        case (r_state)
            CE_IDLE: begin
                if (bus.cmd_valid) begin
                    w_src_base_nxt = bus.cmd_src_base;
                    w_dst_base_nxt = bus.cmd_dst_base;
                    w_length_nxt   = bus.cmd_length;
                    w_src16_nxt    = (bus.cmd_src_dtype == DT_FP16);
                    w_dst16_nxt    = (bus.cmd_dst_dtype == DT_FP16);
                    w_index_nxt    = '0;
                    w_k_nxt        = 1'b0;
                    w_sat_nxt      = '0;
                    w_err_nxt      = !dtype_ok(bus.cmd_src_dtype) || !dtype_ok(bus.cmd_dst_dtype);
                    w_state_nxt    = (w_err_nxt || bus.cmd_length == '0) ? CE_DONE : CE_READ;
                end
            end
            CE_READ: begin
                w_wcnt_nxt  = '0;
                w_state_nxt = CE_WAIT;
            end
            CE_WAIT: begin
                if (w_capture) begin
                    w_k_nxt     = (r_k != r_src16);
                    w_state_nxt = (r_k != r_src16) ? CE_READ : CE_WRITE;
                end else begin
                    w_wcnt_nxt = WC_W'(r_wcnt + 1'b1);
                end
            end
            CE_WRITE: begin
                if (r_k == r_dst16) begin
                    w_k_nxt     = 1'b0;
                    w_index_nxt = LEN_W'(r_index + 1'b1);
                    if (r_src16 && !r_dst16 && w_i8.sat && r_sat_count != '1)
                        w_sat_nxt = LEN_W'(r_sat_count + 1'b1);
                    w_state_nxt = (w_index_nxt == r_length) ? CE_DONE : CE_READ;
                end else begin
                    w_k_nxt = 1'b1;
                end
            end
            CE_DONE: w_state_nxt = CE_IDLE;
            default: w_state_nxt = CE_IDLE;
        endcase

        // Port outputs are registered copies decoded from the next state.
        w_cmd_ready_nxt = (w_state_nxt == CE_IDLE);
        w_busy_nxt      = (w_state_nxt != CE_IDLE);
        w_done_nxt      = (w_state_nxt == CE_DONE);
        w_rd_en_nxt     = (w_state_nxt == CE_READ);
        w_wr_en_nxt     = (w_state_nxt == CE_WRITE);
        if (w_rd_en_nxt)
            w_rd_addr_nxt = w_src_base_nxt + (SRAM0_AW'(w_index_nxt) << w_src16_nxt) + SRAM0_AW'(w_k_nxt);
        if (w_wr_en_nxt) begin
            w_wr_addr_nxt = w_dst_base_nxt + (SRAM0_AW'(w_index_nxt) << w_dst16_nxt) + SRAM0_AW'(w_k_nxt);
            w_wr_data_nxt = w_k_nxt ? w_dst_word[15:8] : w_dst_word[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            r_state     <= CE_IDLE;
            r_src_base  <= '0;
            r_dst_base  <= '0;
            r_length    <= '0;
            r_src16     <= 1'b0;
            r_dst16     <= 1'b0;
            r_index     <= '0;
            r_k         <= 1'b0;
            r_wcnt      <= '0;
            r_src       <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_sat_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_src_base  <= w_src_base_nxt;
            r_dst_base  <= w_dst_base_nxt;
            r_length    <= w_length_nxt;
            r_src16     <= w_src16_nxt;
            r_dst16     <= w_dst16_nxt;
            r_index     <= w_index_nxt;
            r_k         <= w_k_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_src       <= w_src_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_sat_count <= w_sat_nxt;
        end
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.sat_count    = r_sat_count;
    assign bus.sram_rd_en   = r_rd_en;
    assign bus.sram_rd_addr = r_rd_addr;
    assign bus.sram_wr_en   = r_wr_en;
    assign bus.sram_wr_addr = r_wr_addr;
    assign bus.sram_wr_data = r_wr_data;

endmodule

// File: tb/tb_dtype_cast_engine.sv
// Scoreboard bench for dtype_cast_engine: RD_LAT=1 and RD_LAT=3 instances share one SRAM image.
module tb_dtype_cast_engine;
    import dtype_cast_engine_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dtype_cast_engine_if #(.SRAM0_AW(16), .LEN_W(16)) b1 ();
    dtype_cast_engine_if #(.SRAM0_AW(16), .LEN_W(16)) b3 ();

    dtype_cast_engine #(.SRAM0_AW(16), .LEN_W(16), .RD_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    dtype_cast_engine #(.SRAM0_AW(16), .LEN_W(16), .RD_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    logic [7:0] mem [0:65535];
    logic [7:0] r1;
    logic [7:0] p3 [0:2];

    always @(posedge clk) r1 <= b1.sram_rd_en ? mem[b1.sram_rd_addr] : 8'h00;
    always @(posedge clk) begin
        p3[0] <= b3.sram_rd_en ? mem[b3.sram_rd_addr] : 8'h00;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.sram_rd_data = r1;
    assign b3.sram_rd_data = p3[2];

    typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  rd_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", a, d);
        end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(a), 32'(e.addr));
            check("wr_data", 32'(d), 32'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (b1.sram_wr_en) chk_wr(b1.sram_wr_addr, b1.sram_wr_data);
        if (b3.sram_wr_en) chk_wr(b3.sram_wr_addr, b3.sram_wr_data);
        if (b1.sram_rd_en) rd_cnt++;
        if (b3.sram_rd_en) rd_cnt++;
    end

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic issue(input bit sel, input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] len, input logic [7:0] sdt, input logic [7:0] ddt);
        @(posedge clk);
        #1;
        if (!sel) begin
            b1.cmd_src_base = src; b1.cmd_dst_base = dst; b1.cmd_length = len;
            b1.cmd_src_dtype = sdt; b1.cmd_dst_dtype = ddt; b1.cmd_valid = 1'b1;
        end else begin
            b3.cmd_src_base = src; b3.cmd_dst_base = dst; b3.cmd_length = len;
            b3.cmd_src_dtype = sdt; b3.cmd_dst_dtype = ddt; b3.cmd_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        b1.cmd_valid = 1'b0;
        b3.cmd_valid = 1'b0;
    endtask

    // Returns in the cycle done is seen; the accept cycle counts as cycle 1.
    task automatic run(input bit sel, input logic [15:0] src, input logic [15:0] dst,
                       input logic [15:0] len, input logic [7:0] sdt, input logic [7:0] ddt,
                       output int cyc);
        issue(sel, src, dst, len, sdt, ddt);
        cyc = 2;
        while (!(sel ? b3.done : b1.done) && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int rd0;
        int n;
        logic [7:0] t3 [0:15];
        logic [7:0] e3 [0:7];
        b1.cmd_valid = 1'b0; b1.cmd_src_base = '0; b1.cmd_dst_base = '0; b1.cmd_length = '0;
        b1.cmd_src_dtype = '0; b1.cmd_dst_dtype = '0;
        b3.cmd_valid = 1'b0; b3.cmd_src_base = '0; b3.cmd_dst_base = '0; b3.cmd_length = '0;
        b3.cmd_src_dtype = '0; b3.cmd_dst_dtype = '0;

        mem[16'h0100] = 8'h01; mem[16'h0101] = 8'hFF; mem[16'h0102] = 8'h80; mem[16'h0103] = 8'h00;
        mem[16'h0300] = 8'h70; mem[16'h0301] = 8'h41; mem[16'h0302] = 8'h00; mem[16'h0303] = 8'h38;
        mem[16'h0304] = 8'h00; mem[16'h0305] = 8'h3E; mem[16'h0306] = 8'hF8; mem[16'h0307] = 8'h5B;
        mem[16'h0308] = 8'h00; mem[16'h0309] = 8'h7E;
        // -Inf, -128, +Inf, -1.5, min subnormal, 0.75, -129, 2.5
        t3 = '{8'h00, 8'hFC, 8'h00, 8'hD8, 8'h00, 8'h7C, 8'h00, 8'hBE,
               8'h01, 8'h00, 8'h00, 8'h3A, 8'h08, 8'hD8, 8'h00, 8'h41};
        e3 = '{8'h80, 8'h80, 8'h7F, 8'hFE, 8'h00, 8'h01, 8'h80, 8'h02};
        for (int i = 0; i < 16; i++) mem[16'h0500 + 16'(i)] = t3[i];
        mem[16'h0600] = 8'hAB; mem[16'h0601] = 8'hCD; mem[16'h0602] = 8'h12; mem[16'h0603] = 8'h34;
        mem[16'h0800] = 8'h11; mem[16'h0801] = 8'h22; mem[16'h0802] = 8'h33;
        mem[16'h0A00] = 8'h05;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(b1.cmd_ready), 32'd1);
        check("rst_busy", 32'(b1.busy), 32'd0);
        check("rst_done", 32'(b1.done), 32'd0);
        check("rst_err", 32'(b1.err), 32'd0);
        check("rst_sat", 32'(b1.sat_count), 32'd0);
        check("rst_rd_en", 32'(b1.sram_rd_en), 32'd0);
        check("rst_wr_en", 32'(b1.sram_wr_en), 32'd0);
        check("rst_rd_addr", 32'(b1.sram_rd_addr), 32'd0);
        check("rst_wr_data", 32'(b1.sram_wr_data), 32'd0);
        check("rst_ready3", 32'(b3.cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // INT8 -> FP16
        push(16'h0200, 8'h00); push(16'h0201, 8'h3C); push(16'h0202, 8'h00); push(16'h0203, 8'hBC);
        push(16'h0204, 8'h00); push(16'h0205, 8'hD8); push(16'h0206, 8'h00); push(16'h0207, 8'h00);
        run(1'b0, 16'h0100, 16'h0200, 16'd4, DT_INT8, DT_FP16, cyc);
        check("t1_cycles", 32'(cyc), 32'd18);
        check("t1_sat", 32'(b1.sat_count), 32'd0);
        check("t1_err", 32'(b1.err), 32'd0);
        check("t1_drain", 32'(exp_q.size()), 32'd0);

        // FP16 -> INT8 with rounding, clamp and NaN
        push(16'h0400, 8'h03); push(16'h0401, 8'h00); push(16'h0402, 8'h02);
        push(16'h0403, 8'h7F); push(16'h0404, 8'h00);
        run(1'b0, 16'h0300, 16'h0400, 16'd5, DT_FP16, DT_INT8, cyc);
        check("t2_cycles", 32'(cyc), 32'd27);
        check("t2_sat", 32'(b1.sat_count), 32'd2);

        // FP16 -> INT8 infinities, exact -128, negative rounding, subnormal
        for (int i = 0; i < 8; i++) push(16'h0580 + 16'(i), e3[i]);
        run(1'b0, 16'h0500, 16'h0580, 16'd8, DT_FP16, DT_INT8, cyc);
        check("t3_cycles", 32'(cyc), 32'd42);
        check("t3_sat", 32'(b1.sat_count), 32'd3);

        // FP16 copy
        push(16'h0700, 8'hAB); push(16'h0701, 8'hCD); push(16'h0702, 8'h12); push(16'h0703, 8'h34);
        run(1'b0, 16'h0600, 16'h0700, 16'd2, DT_FP16, DT_FP16, cyc);
        check("t4_cycles", 32'(cyc), 32'd14);

        // INT8 copy with RD_LAT=3: 1+3 read cycles + 1 write per element
        rd0 = rd_cnt;
        push(16'h0900, 8'h11); push(16'h0901, 8'h22); push(16'h0902, 8'h33);
        run(1'b1, 16'h0800, 16'h0900, 16'd3, DT_INT8, DT_INT8, cyc);
        check("t5_cycles", 32'(cyc), 32'd17);
        check("t5_reads", 32'(rd_cnt - rd0), 32'd3);

        // Unsupported dtype, then zero-length command clears err
        rd0 = rd_cnt;
        run(1'b0, 16'h0100, 16'h0C00, 16'd4, 8'd2, DT_INT8, cyc);
        check("t6_cycles", 32'(cyc), 32'd2);
        check("t6_err", 32'(b1.err), 32'd1);
        @(posedge clk);
        #1;
        check("t6_err_held", 32'(b1.err), 32'd1);
        check("t6_idle", 32'(b1.busy), 32'd0);
        run(1'b0, 16'h0100, 16'h0C00, 16'd0, DT_INT8, DT_FP16, cyc);
        check("t6z_cycles", 32'(cyc), 32'd2);
        check("t6z_err", 32'(b1.err), 32'd0);
        check("t6_reads", 32'(rd_cnt - rd0), 32'd0);

        // Destination address wrap
        push(16'hFFFF, 8'h00); push(16'h0000, 8'h45);
        run(1'b0, 16'h0A00, 16'hFFFF, 16'd1, DT_INT8, DT_FP16, cyc);
        check("t7_cycles", 32'(cyc), 32'd6);
        check("t7_drain", 32'(exp_q.size()), 32'd0);

        // Reset after two elements of an FP16 -> INT8 command
        push(16'h0B00, 8'h03); push(16'h0B01, 8'h00); push(16'h0B02, 8'h02);
        push(16'h0B03, 8'h7F); push(16'h0B04, 8'h00);
        issue(1'b0, 16'h0300, 16'h0B00, 16'd5, DT_FP16, DT_INT8);
        n = 0;
        while (exp_q.size() > 3 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t8_progress", 32'(exp_q.size()), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t8_busy", 32'(b1.busy), 32'd0);
        check("t8_ready", 32'(b1.cmd_ready), 32'd1);
        check("t8_rd_en", 32'(b1.sram_rd_en), 32'd0);
        check("t8_wr_en", 32'(b1.sram_wr_en), 32'd0);
        check("t8_wr_addr", 32'(b1.sram_wr_addr), 32'd0);
        exp_q.delete();
        rd0 = rd_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t8_no_reads", 32'(rd_cnt - rd0), 32'd0);
        push(16'h0B00, 8'h03); push(16'h0B01, 8'h00); push(16'h0B02, 8'h02);
        push(16'h0B03, 8'h7F); push(16'h0B04, 8'h00);
        run(1'b0, 16'h0300, 16'h0B00, 16'd5, DT_FP16, DT_INT8, cyc);
        check("t8_cycles", 32'(cyc), 32'd27);
        check("t8_sat", 32'(b1.sat_count), 32'd2);

        repeat (3) @(posedge clk);
        #1;
        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
